alarm_timekeeper: RTL and testbench

ALARM_TIMEKEEPER -- requirements
Module: alarm_timekeeper

---
 rtl/alarm_pkg.sv | 30 +++
 rtl/bcd2_counter.sv | 34 +++
 rtl/alarm_timekeeper.sv | 143 ++++++++++++++
 tb/tb_alarm_timekeeper.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock: mode encodings, BCD limits and the
// two-digit BCD increment used by every time and alarm field.
package alarm_pkg;

    typedef enum logic [2:0] {
        MODE_RUN    = 3'd0,
        MODE_SET_H  = 3'd1,
        MODE_SET_M  = 3'd2,
        MODE_SET_AH = 3'd3,
        MODE_SET_AM = 3'd4
    } mode_e;

    localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR = 8'h23;
    localparam logic [7:0] ALARM_H_RST  = 8'h07;
    localparam int         RING_TICKS   = 60;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with wrap at MAX; nxt exposes the value that will be
// loaded on the coming edge so the parent can detect alarm matches early.
module bcd2_counter
    import alarm_pkg::*;
#(
    parameter logic [7:0] MAX     = 8'h59,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clear,
    output logic [7:0] q,
    output logic [7:0] nxt,
    output logic       carry
);

    always_comb begin
        nxt   = q;
        carry = inc && (q == MAX);
        if (clear)
            nxt = 8'h00;
        else if (inc)
            nxt = bcd_next(q, MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RST_VAL;
        else
            q <= nxt;
    end

endmodule

// File: rtl/alarm_timekeeper.sv
// Alarm clock: 1 s prescaler, BCD HH:MM:SS time, settable alarm and ring timer.
//   state       | meaning
//   MODE_RUN    | time runs, key_ack arms/disarms the alarm
//   MODE_SET_H  | time frozen, key_inc bumps hours
//   MODE_SET_M  | time frozen, key_inc bumps minutes; leaving clears seconds
//   MODE_SET_AH | time runs, key_inc bumps alarm hour
//   MODE_SET_AM | time runs, key_inc bumps alarm minute
module alarm_timekeeper
    import alarm_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic        key_ack,
    output logic [23:0] num,
    output logic [2:0]  mode,
    output logic        alarm_en,
    output logic        ring
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]     RING_LOAD  = 6'(RING_TICKS - 1);

    mode_e         mode_q, mode_d;
    logic [PW-1:0] presc_q;
    logic          tick, time_run, leave_set_m, edit;
    logic [7:0]    ss_q, mm_q, hh_q, am_q, ah_q;
    logic [7:0]    ss_nxt, mm_nxt, hh_nxt, am_nxt, ah_nxt;
    logic          ss_carry, mm_carry, hh_carry, am_carry, ah_carry;
    logic          en_d, ring_set, ring_d;
    logic [5:0]    ring_cnt, ring_cnt_d;
    logic          unused_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= MODE_RUN;
        else
            mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (key_mode) begin
            case (mode_q)
                MODE_RUN:    mode_d = MODE_SET_H;
                MODE_SET_H:  mode_d = MODE_SET_M;
                MODE_SET_M:  mode_d = MODE_SET_AH;
                MODE_SET_AH: mode_d = MODE_SET_AM;
                default:     mode_d = MODE_RUN;
            endcase
        end
    end

    assign time_run    = (mode_q != MODE_SET_H) && (mode_q != MODE_SET_M);
    assign leave_set_m = key_mode && (mode_q == MODE_SET_M);
    assign edit        = key_inc && !key_mode;
    assign tick        = time_run && (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc_q <= '0;
        else if (leave_set_m)
            presc_q <= '0;
        else if (time_run)
            presc_q <= tick ? '0 : presc_q + PW'(1);
    end

    bcd2_counter #(.MAX(BCD_MAX_MIN), .RST_VAL(8'h00)) u_ss (
        .clk(clk), .rst_n(rst_n), .inc(tick), .clear(leave_set_m),
        .q(ss_q), .nxt(ss_nxt), .carry(ss_carry)
    );

    // An edit wrap of minutes must not ripple into hours: hours only follow a tick carry.
    bcd2_counter #(.MAX(BCD_MAX_MIN), .RST_VAL(8'h00)) u_mm (
        .clk(clk), .rst_n(rst_n), .inc(ss_carry || (edit && mode_q == MODE_SET_M)), .clear(1'b0),
        .q(mm_q), .nxt(mm_nxt), .carry(mm_carry)
    );

    bcd2_counter #(.MAX(BCD_MAX_HOUR), .RST_VAL(8'h00)) u_hh (
        .clk(clk), .rst_n(rst_n),
        .inc((ss_carry && mm_carry) || (edit && mode_q == MODE_SET_H)), .clear(1'b0),
        .q(hh_q), .nxt(hh_nxt), .carry(hh_carry)
    );

    bcd2_counter #(.MAX(BCD_MAX_HOUR), .RST_VAL(ALARM_H_RST)) u_ah (
        .clk(clk), .rst_n(rst_n), .inc(edit && mode_q == MODE_SET_AH), .clear(1'b0),
        .q(ah_q), .nxt(ah_nxt), .carry(ah_carry)
    );

    bcd2_counter #(.MAX(BCD_MAX_MIN), .RST_VAL(8'h00)) u_am (
        .clk(clk), .rst_n(rst_n), .inc(edit && mode_q == MODE_SET_AM), .clear(1'b0),
        .q(am_q), .nxt(am_nxt), .carry(am_carry)
    );

    assign unused_ok = &{1'b0, hh_carry, ah_carry, am_carry, ah_nxt, am_nxt};

    assign en_d = alarm_en ^ (key_ack && (mode_q == MODE_RUN) && !ring);

    // A tick only zeroes seconds when they roll over, so this fires once per match.
    assign ring_set = tick && en_d && (ss_nxt == 8'h00) && (mm_nxt == am_q) && (hh_nxt == ah_q);

    always_comb begin
        ring_d     = ring;
        ring_cnt_d = ring_cnt;
        if (ring_set) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_LOAD;
        end else if (!en_d) begin
            ring_d = 1'b0;
        end else if (ring && key_ack) begin
            ring_d = 1'b0;
        end else if (ring && tick) begin
            if (ring_cnt == 6'd0)
                ring_d = 1'b0;
            else
                ring_cnt_d = ring_cnt - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_en <= 1'b0;
            ring     <= 1'b0;
            ring_cnt <= 6'd0;
            num      <= 24'h000000;
        end else begin
            alarm_en <= en_d;
            ring     <= ring_d;
            ring_cnt <= ring_cnt_d;
            if (mode_q == MODE_SET_AH || mode_q == MODE_SET_AM)
                num <= {ah_q, am_q, 8'h00};
            else
                num <= {hh_q, mm_q, ss_q};
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Scoreboarded bench: a seconds-of-day reference model predicts every cycle's
// outputs, a monitor compares them, and directed checks cover the key scenarios.
module tb_alarm_timekeeper;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_mode = 1'b0, key_inc = 1'b0, key_ack = 1'b0;
    logic [23:0] num;
    logic [2:0]  mode;
    logic        alarm_en, ring;

    alarm_timekeeper #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc), .key_ack(key_ack),
        .num(num), .mode(mode), .alarm_en(alarm_en), .ring(ring)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] num;
        logic [2:0]  mode;
        logic        en;
        logic        ring;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state
    int secs, ah, am, md, presc, ring_left;
    bit en, rng;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] disp();
        if (md >= 3)
            return {bcd(ah), bcd(am), 8'h00};
        return {bcd(secs / 3600), bcd((secs / 60) % 60), bcd(secs % 60)};
    endfunction

    task automatic model_reset();
        secs = 0; ah = 7; am = 0; md = 0; presc = 0; ring_left = 0; en = 0; rng = 0;
    endtask

    task automatic model_update(input bit m, input bit i, input bit a, output exp_t e);
        logic [23:0] n_num;
        bit run_t, tick, n_en, set;
        int old_ah, old_am, h, mi;
        n_num  = disp();
        run_t  = !(md == 1 || md == 2);
        tick   = run_t && (presc == TD - 1);
        old_ah = ah;
        old_am = am;
        if (md == 2 && m)
            presc = 0;
        else if (run_t)
            presc = tick ? 0 : presc + 1;
        if (tick)
            secs = (secs + 1) % 86400;
        if (i && !m) begin
            h  = secs / 3600;
            mi = (secs / 60) % 60;
            case (md)
                1: secs = ((h + 1) % 24) * 3600 + secs % 3600;
                2: secs = h * 3600 + ((mi + 1) % 60) * 60 + secs % 60;
                3: ah = (ah + 1) % 24;
                4: am = (am + 1) % 60;
                default: ;
            endcase
        end
        if (md == 2 && m)
            secs = secs - secs % 60;
        n_en = en ^ (a && md == 0 && !rng);
        set  = tick && n_en && (secs == old_ah * 3600 + old_am * 60);
        if (set) begin
            rng = 1; ring_left = 60;
        end else if (!n_en) begin
            rng = 0;
        end else if (rng && a) begin
            rng = 0;
        end else if (rng && tick) begin
            ring_left--;
            if (ring_left == 0) rng = 0;
        end
        en = n_en;
        if (m) md = (md + 1) % 5;
        e = '{num: n_num, mode: 3'(md), en: en, ring: rng};
    endtask

    task automatic step(input bit m, input bit i, input bit a);
        exp_t e;
        @(negedge clk);
        key_mode = m; key_inc = i; key_ack = a;
        model_update(m, i, a, e);
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        key_mode = 0; key_inc = 0; key_ack = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_num", 32'(num), 32'h0);
        check("rst_mode", 32'(mode), 32'h0);
        check("rst_en", 32'(alarm_en), 32'h0);
        check("rst_ring", 32'(ring), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_update(0, 0, 0, e);
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    // Set time to h:mi:00 through the edit modes and return to RUN.
    task automatic goto_time(input int h, input int mi);
        step(1, 0, 0);
        repeat ((h - secs / 3600 + 24) % 24) step(0, 1, 0);
        step(1, 0, 0);
        repeat ((mi - (secs / 60) % 60 + 60) % 60) step(0, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
    endtask

    task automatic wait_ring(input logic lvl, input int limit, output int n);
        n = 0;
        while (ring !== lvl && n < limit) begin
            step(0, 0, 0);
            #1;
            n++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_num", 32'(num), 32'(e.num));
                check("sb_mode", 32'(mode), 32'(e.mode));
                check("sb_en", 32'(alarm_en), 32'(e.en));
                check("sb_ring", 32'(ring), 32'(e.ring));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        model_reset();
        do_reset();

        // One minute of free running
        repeat (240) step(0, 0, 0);
        #1;
        check("one_minute_num", 32'(num), 32'h000100);
        check("one_minute_mode", 32'(mode), 32'h0);

        // Day wrap
        goto_time(23, 59);
        repeat (235) step(0, 0, 0);
        #1;
        check("pre_wrap_num", 32'(num), 32'h235959);
        repeat (4) step(0, 0, 0);
        #1;
        check("wrap_num", 32'(num), 32'h000000);

        // Alarm hour edit
        do_reset();
        repeat (3) step(1, 0, 0);
        repeat (2) step(0, 1, 0);
        #1;
        check("set_ah_mode", 32'(mode), 32'h3);
        step(0, 0, 0);
        #1;
        check("set_ah_num", 32'(num), 32'h090000);
        repeat (2) step(1, 0, 0);
        #1;
        check("back_to_run", 32'(mode), 32'h0);

        // Ring at 07:00:00 and self-clear after 60 ticks
        do_reset();
        step(0, 0, 1);
        #1;
        check("arm_en", 32'(alarm_en), 32'h1);
        goto_time(6, 59);
        wait_ring(1'b1, 400, n);
        check("ring_rise_cycles", 32'(n), 32'd238);
        step(0, 0, 0);
        #1;
        check("ring_num", 32'(num), 32'h070000);
        wait_ring(1'b0, 400, n);
        check("ring_len_cycles", 32'(n), 32'd239);

        // Acknowledge, then disarm
        goto_time(6, 59);
        wait_ring(1'b1, 400, n);
        check("ring2_rise_cycles", 32'(n), 32'd238);
        step(0, 0, 1);
        #1;
        check("ack_ring", 32'(ring), 32'h0);
        check("ack_keeps_en", 32'(alarm_en), 32'h1);
        step(0, 0, 1);
        #1;
        check("ack_disarm", 32'(alarm_en), 32'h0);

        // key_mode wins over key_inc
        step(1, 0, 0);
        step(1, 1, 0);
        #1;
        check("mode_over_inc", 32'(mode), 32'h2);
        step(0, 0, 0);
        #1;
        check("hours_unchanged", 32'(num[23:16]), 32'h07);
        repeat (3) step(1, 0, 0);

        // Reset in the middle of a ring; first tick TD cycles after release
        step(0, 0, 1);
        goto_time(6, 59);
        wait_ring(1'b1, 400, n);
        check("ring3_rise_cycles", 32'(n), 32'd238);
        repeat (10) step(0, 0, 0);
        do_reset();
        repeat (3) step(0, 0, 0);
        #1;
        check("no_early_tick", 32'(num), 32'h000000);
        step(0, 0, 0);
        #1;
        check("first_tick", 32'(num), 32'h000001);

        // Randomized keys around an armed alarm
        step(0, 0, 1);
        goto_time(6, 57);
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                do_reset();
                step(0, 0, 1);
                goto_time(6, 58);
            end
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 47) == 0);
        end
        step(0, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
